// File: rtl/cdd_sector_seq_if.sv
// Word-source, DMA handshake and status bundle of the CD-drive sector sequencer.
// The slave side is the sequencer; the master side is its surroundings.
interface cdd_sector_seq_if;
    logic        CE;
    logic        EN;
    logic        WORD_VALID;
    logic [15:0] WORD_DI;
    logic        WORD_RD;
    logic        DACK;
    logic        DREQ_N;
    logic [15:0] DATA_DO;
    logic [31:0] HEADER;
    logic        SYNCED;
    logic        SECT_IRQ;
    logic        SYNC_ERR;
    logic [7:0]  SECT_CNT;

    modport master (
        output CE, EN, WORD_VALID, WORD_DI, DACK,
        input  WORD_RD, DREQ_N, DATA_DO, HEADER, SYNCED, SECT_IRQ, SYNC_ERR, SECT_CNT
    );

    modport slave (
        input  CE, EN, WORD_VALID, WORD_DI, DACK,
        output WORD_RD, DREQ_N, DATA_DO, HEADER, SYNCED, SECT_IRQ, SYNC_ERR, SECT_CNT
    );
endinterface

// File: rtl/cdd_sector_seq.sv
// CD-drive sector sequencer: hunts the sync pattern, frames raw sectors, captures the
// header and hands each remaining word to DMA channel 0 over a DREQ/DACK handshake.
module cdd_sector_seq #(
    parameter int SECTOR_WORDS = 1176,
    parameter int SYNC_WORDS   = 6
) (
    input  logic            CLK,
    input  logic            RST_N,
    cdd_sector_seq_if.slave bus
);
    localparam int WIW = $clog2(SECTOR_WORDS);
    localparam int SIW = $clog2(SYNC_WORDS + 1);
    localparam logic [WIW-1:0] WI_LAST = WIW'(SECTOR_WORDS - 1);
    localparam logic [WIW-1:0] WI_HDR0 = WIW'(SYNC_WORDS);
    localparam logic [WIW-1:0] WI_HDR1 = WIW'(SYNC_WORDS + 1);
    localparam logic [SIW-1:0] SI_LAST = SIW'(SYNC_WORDS - 1);

    typedef enum logic [1:0] {HUNT, FETCH, XFER, CHECK} state_t;

    function automatic logic [15:0] sync_word(input logic [SIW-1:0] idx);
        if (idx == '0)
            return 16'h00FF;
        else if (idx == SI_LAST)
            return 16'hFF00;
        else
            return 16'hFFFF;
    endfunction

    state_t           state_reg, state_next;
    logic [SIW-1:0]   si_reg, si_next;
    logic [WIW-1:0]   wi_reg, wi_next;
    logic             dreq_n_reg, dreq_n_next;
    logic [15:0]      data_reg, data_next;
    logic [31:0]      header_reg, header_next;
    logic             synced_reg, synced_next;
    logic             irq_reg, irq_next;
    logic             err_reg, err_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic             dack_reg, dack_next;
    logic             word_rd;
    logic             step;
    logic             sync_hit;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg  <= HUNT;
            si_reg     <= '0;
            wi_reg     <= '0;
            dreq_n_reg <= 1'b1;
            data_reg   <= '0;
            header_reg <= '0;
            synced_reg <= 1'b0;
            irq_reg    <= 1'b0;
            err_reg    <= 1'b0;
            cnt_reg    <= '0;
            dack_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            si_reg     <= si_next;
            wi_reg     <= wi_next;
            dreq_n_reg <= dreq_n_next;
            data_reg   <= data_next;
            header_reg <= header_next;
            synced_reg <= synced_next;
            irq_reg    <= irq_next;
            err_reg    <= err_next;
            cnt_reg    <= cnt_next;
            dack_reg   <= dack_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        si_next     = si_reg;
        wi_next     = wi_reg;
        dreq_n_next = dreq_n_reg;
        data_next   = data_reg;
        header_next = header_reg;
        synced_next = synced_reg;
        irq_next    = 1'b0;
        err_next    = 1'b0;
        cnt_next    = cnt_reg;
        dack_next   = dack_reg;
        step        = 1'b0;
        sync_hit    = (bus.WORD_DI == sync_word(si_reg));

        if (bus.CE)
            dack_next = bus.DACK;

        case (state_reg)
            HUNT: begin
                if (word_rd) begin
                    if (sync_hit) begin
                        if (si_reg == SI_LAST) begin
                            synced_next = 1'b1;
                            wi_next     = WI_HDR0;
                            si_next     = '0;
                            state_next  = FETCH;
                        end else begin
                            si_next = si_reg + SIW'(1);
                        end
                    end else begin
                        // 00FF can only ever begin the pattern, so it is the sole restart point
                        si_next = (bus.WORD_DI == 16'h00FF) ? SIW'(1) : '0;
                    end
                end
            end
            FETCH: begin
                if (word_rd) begin
                    data_next = bus.WORD_DI;
                    if (wi_reg == WI_HDR0)
                        header_next[31:16] = bus.WORD_DI;
                    if (wi_reg == WI_HDR1)
                        header_next[15:0] = bus.WORD_DI;
                    if (bus.EN) begin
                        dreq_n_next = 1'b0;
                        state_next  = XFER;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            XFER: begin
                if (bus.CE && (!bus.EN || (bus.DACK && !dack_reg))) begin
                    dreq_n_next = 1'b1;
                    step        = 1'b1;
                end
            end
            CHECK: begin
                if (word_rd) begin
                    if (sync_hit) begin
                        if (si_reg == SI_LAST) begin
                            wi_next    = WI_HDR0;
                            si_next    = '0;
                            state_next = FETCH;
                        end else begin
                            si_next = si_reg + SIW'(1);
                        end
                    end else begin
                        err_next    = 1'b1;
                        synced_next = 1'b0;
                        si_next     = '0;
                        state_next  = HUNT;
                    end
                end
            end
            default: state_next = HUNT;
        endcase

        // A word has been handed over or dropped: advance framing
        if (step) begin
            if (wi_reg == WI_LAST) begin
                irq_next   = 1'b1;
                cnt_next   = cnt_reg + 8'd1;
                wi_next    = '0;
                si_next    = '0;
                state_next = CHECK;
            end else begin
                wi_next    = wi_reg + WIW'(1);
                state_next = FETCH;
            end
        end
    end

    always_comb begin
        word_rd = RST_N && bus.CE && bus.WORD_VALID && (state_reg != XFER);
    end

    assign bus.WORD_RD  = word_rd;
    assign bus.DREQ_N   = dreq_n_reg;
    assign bus.DATA_DO  = data_reg;
    assign bus.HEADER   = header_reg;
    assign bus.SYNCED   = synced_reg;
    assign bus.SECT_IRQ = irq_reg;
    assign bus.SYNC_ERR = err_reg;
    assign bus.SECT_CNT = cnt_reg;
endmodule

// File: tb/tb_cdd_sector_seq.sv
// Randomized bench for cdd_sector_seq; expected words, header and counts come from a
// stream-level model that locates sync patterns by substring search over the stimulus.
module tb_cdd_sector_seq;
    localparam int SW = 1176;
    localparam int NS = 6;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    cdd_sector_seq_if bus();
    cdd_sector_seq #(.SECTOR_WORDS(SW), .SYNC_WORDS(NS)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

    int checks = 0;
    int passed = 0;
    logic [15:0] stim[$];
    logic [15:0] src_q[$];
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic [31:0] exp_hdr;
    int exp_irqs, exp_errs;
    bit exp_synced;
    int pops, irqs, errs, dreqs, bad_rd, err_pop;
    logic err_synced;

    function automatic logic [15:0] pat(input int k);
        return (k == 0) ? 16'h00FF : ((k == NS - 1) ? 16'hFF00 : 16'hFFFF);
    endfunction

    function automatic void push_sync();
        for (int k = 0; k < NS; k++) stim.push_back(pat(k));
    endfunction

    function automatic void push_body(input logic [15:0] h0, input logic [15:0] h1);
        stim.push_back(h0);
        stim.push_back(h1);
        for (int k = 0; k < SW - NS - 2; k++) stim.push_back(16'($urandom));
    endfunction

    function automatic bit sync_at(input int p);
        if (p + NS > stim.size()) return 1'b0;
        for (int k = 0; k < NS; k++)
            if (stim[p + k] != pat(k)) return 1'b0;
        return 1'b1;
    endfunction

    // Walk the stream: search for sync, deliver a sector body, expect sync again.
    function automatic void model();
        int pos = 0;
        bit locked = 1'b0;
        int found;
        exp_q.delete();
        exp_hdr = '0;
        exp_irqs = 0;
        exp_errs = 0;
        while (1) begin
            if (!locked) begin
                found = -1;
                for (int p = pos; p + NS <= stim.size(); p++)
                    if (sync_at(p)) begin found = p; break; end
                if (found < 0) begin exp_synced = 1'b0; return; end
                pos = found + NS;
                locked = 1'b1;
            end
            for (int k = 0; k < SW - NS; k++) begin
                if (pos >= stim.size()) begin exp_synced = 1'b1; return; end
                if (k == 0) exp_hdr[31:16] = stim[pos];
                if (k == 1) exp_hdr[15:0] = stim[pos];
                exp_q.push_back(stim[pos]);
                pos++;
            end
            exp_irqs++;
            for (int k = 0; k < NS; k++) begin
                if (pos >= stim.size()) begin exp_synced = 1'b1; return; end
                pos++;
                if (stim[pos - 1] != pat(k)) begin exp_errs++; locked = 1'b0; break; end
            end
        end
    endfunction

    function automatic int first_diff();
        int n = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (i >= got_q.size() || i >= exp_q.size() || got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        RST_N = 1'b0;
        bus.CE = 1'b0;
        bus.EN = 1'b0;
        bus.WORD_VALID = 1'b0;
        bus.WORD_DI = '0;
        bus.DACK = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        pops = 0; irqs = 0; errs = 0; dreqs = 0; bad_rd = 0; err_pop = -1; err_synced = 1'bx;
        src_q.delete();
        got_q.delete();
        stim.delete();
    endtask

    // Cycle engine: source FIFO, DMA responder, event counters. Inputs change on negedge.
    task automatic run(input bit en, input bit toggle, input bit spur, input int lat_lo,
                       input int lat_hi, input int ce_pct, input int stop_at, input string tag);
        bit pend = 1'b0;
        bit prev_dreq = 1'b1;
        bit ce_prev;
        int lat = 1;
        int wcnt = 0;
        int idle = 0;
        src_q = stim;
        bus.EN = en;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            @(negedge CLK);
            ce_prev = bus.CE;
            if (pend) begin void'(src_q.pop_front()); pops++; end
            if (bus.SYNC_ERR) begin errs++; err_pop = pops; err_synced = bus.SYNCED; end
            if (bus.SECT_IRQ) irqs++;
            if (!bus.DREQ_N) begin
                if (prev_dreq) begin
                    dreqs++;
                    got_q.push_back(bus.DATA_DO);
                    lat = $urandom_range(lat_hi, lat_lo);
                    wcnt = 0;
                end else if (ce_prev && !bus.DACK) begin
                    wcnt++;
                end
                bus.DACK = (wcnt >= lat);
            end else begin
                bus.DACK = spur && ($urandom_range(3, 0) == 0);
            end
            prev_dreq = bus.DREQ_N;
            if (stop_at >= 0 && got_q.size() == stop_at && !bus.DREQ_N) return;
            bus.CE = ($urandom_range(99, 0) < ce_pct);
            bus.WORD_VALID = (src_q.size() > 0) && (!toggle || cyc[0]);
            bus.WORD_DI = (src_q.size() > 0) ? src_q[0] : 16'($urandom);
            #1;
            pend = bus.WORD_RD;
            if (bus.WORD_RD && !(bus.WORD_VALID && bus.CE)) bad_rd++;
            if (src_q.size() == 0 && bus.DREQ_N && !pend) idle++; else idle = 0;
            if (idle > 8) return;
        end
        checks++;
        $display("FAIL %s_timeout words_left=%0d delivered=%0d", tag, src_q.size(), got_q.size());
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        bus.CE = 1'b1; bus.EN = 1'b1; bus.WORD_VALID = 1'b1; bus.WORD_DI = 16'h00FF; bus.DACK = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if ({bus.DREQ_N, bus.SYNCED, bus.SECT_IRQ, bus.SYNC_ERR, bus.WORD_RD, bus.SECT_CNT, bus.DATA_DO, bus.HEADER}
            !== {1'b1, 4'b0, 8'h0, 16'h0, 32'h0})
            $display("FAIL reset_values got %h want %h",
                     {bus.DREQ_N, bus.SYNCED, bus.SECT_IRQ, bus.SYNC_ERR, bus.WORD_RD, bus.SECT_CNT, bus.DATA_DO, bus.HEADER},
                     {1'b1, 4'b0, 8'h0, 16'h0, 32'h0});
        else passed++;
        RST_N = 1'b1;
        #1;
        checks++;
        if (bus.WORD_RD !== 1'b1) $display("FAIL reset_pop_comb got %b want 1", bus.WORD_RD); else passed++;
    endtask

    task automatic test_clean();
        do_reset();
        for (int k = 0; k < 3; k++) stim.push_back(16'($urandom));
        push_sync();
        push_body(16'h0102, 16'h0362);
        model();
        run(1'b1, 1'b0, 1'b0, 2, 2, 100, -1, "clean");
        checks++; if (first_diff() != -1) $display("FAIL clean_order first_diff=%0d got_n=%0d want_n=%0d", first_diff(), got_q.size(), exp_q.size()); else passed++;
        checks++; if (dreqs != 1170) $display("FAIL clean_dreqs got %0d want 1170", dreqs); else passed++;
        checks++; if (bus.HEADER !== 32'h01020362) $display("FAIL clean_header got %h want 01020362", bus.HEADER); else passed++;
        checks++; if (irqs != 1) $display("FAIL clean_irqs got %0d want 1", irqs); else passed++;
        checks++; if (bus.SECT_CNT !== 8'd1) $display("FAIL clean_sect_cnt got %0d want 1", bus.SECT_CNT); else passed++;
        checks++; if (bus.SYNCED !== 1'b1) $display("FAIL clean_synced got %b want 1", bus.SYNCED); else passed++;
        checks++; if (pops != stim.size()) $display("FAIL clean_pops got %0d want %0d", pops, stim.size()); else passed++;
        checks++; if (bad_rd != 0) $display("FAIL clean_bad_rd got %0d want 0", bad_rd); else passed++;
    endtask

    task automatic test_false_sync();
        do_reset();
        stim.push_back(16'h00FF);
        stim.push_back(16'hFFFF);
        push_sync();
        for (int k = 0; k < 8; k++) stim.push_back(16'($urandom));
        model();
        run(1'b1, 1'b0, 1'b0, 1, 3, 70, -1, "false_sync");
        checks++; if (got_q.size() == 0 || got_q[0] !== stim[8]) $display("FAIL false_sync_first got %h want %h", (got_q.size() > 0) ? got_q[0] : 16'hxxxx, stim[8]); else passed++;
        checks++; if (first_diff() != -1) $display("FAIL false_sync_order first_diff=%0d got_n=%0d want_n=%0d", first_diff(), got_q.size(), exp_q.size()); else passed++;
        checks++; if (bus.HEADER !== {stim[8], stim[9]}) $display("FAIL false_sync_header got %h want %h", bus.HEADER, {stim[8], stim[9]}); else passed++;
        checks++; if (bus.SYNCED !== 1'b1 || irqs != 0) $display("FAIL false_sync_state synced=%b irqs=%0d want 1/0", bus.SYNCED, irqs); else passed++;
    endtask

    task automatic test_en_off();
        do_reset();
        push_sync();
        push_body(16'($urandom), 16'($urandom));
        model();
        run(1'b0, 1'b0, 1'b0, 1, 1, 60, -1, "en_off");
        checks++; if (dreqs != 0) $display("FAIL en_off_dreqs got %0d want 0", dreqs); else passed++;
        checks++; if (pops != SW) $display("FAIL en_off_pops got %0d want %0d", pops, SW); else passed++;
        checks++; if (irqs != 1 || bus.SECT_CNT !== 8'd1) $display("FAIL en_off_sector irqs=%0d cnt=%0d want 1/1", irqs, bus.SECT_CNT); else passed++;
        checks++; if (bus.HEADER !== exp_hdr) $display("FAIL en_off_header got %h want %h", bus.HEADER, exp_hdr); else passed++;
    endtask

    task automatic test_sync_err();
        int bad_idx;
        do_reset();
        push_sync();
        push_body(16'($urandom), 16'($urandom));
        bad_idx = stim.size() + 3;
        push_sync();
        stim[bad_idx] = 16'hFFFE;
        push_body(16'($urandom), 16'($urandom));
        for (int k = 0; k < 5; k++) stim.push_back(16'($urandom));
        push_sync();
        push_body(16'($urandom), 16'($urandom));
        model();
        run(1'b1, 1'b0, 1'b0, 1, 2, 100, -1, "sync_err");
        checks++; if (errs != 1 || exp_errs != 1) $display("FAIL sync_err_count got %0d want 1", errs); else passed++;
        checks++; if (err_pop != bad_idx + 1) $display("FAIL sync_err_position got %0d want %0d", err_pop, bad_idx + 1); else passed++;
        checks++; if (err_synced !== 1'b0) $display("FAIL sync_err_synced got %b want 0", err_synced); else passed++;
        checks++; if (irqs != 2 || bus.SECT_CNT !== 8'd2) $display("FAIL sync_err_sectors irqs=%0d cnt=%0d want 2/2", irqs, bus.SECT_CNT); else passed++;
        checks++; if (bus.SYNCED !== exp_synced) $display("FAIL sync_err_relock got %b want %b", bus.SYNCED, exp_synced); else passed++;
        checks++; if (first_diff() != -1) $display("FAIL sync_err_order first_diff=%0d got_n=%0d want_n=%0d", first_diff(), got_q.size(), exp_q.size()); else passed++;
        checks++; if (bus.HEADER !== exp_hdr) $display("FAIL sync_err_header got %h want %h", bus.HEADER, exp_hdr); else passed++;
    endtask

    task automatic test_valid_toggle();
        do_reset();
        push_sync();
        push_body(16'($urandom), 16'($urandom));
        model();
        run(1'b1, 1'b1, 1'b1, 1, 4, 100, -1, "toggle");
        checks++; if (first_diff() != -1) $display("FAIL toggle_order first_diff=%0d got_n=%0d want_n=%0d", first_diff(), got_q.size(), exp_q.size()); else passed++;
        checks++; if (pops != stim.size()) $display("FAIL toggle_pops got %0d want %0d", pops, stim.size()); else passed++;
        checks++; if (dreqs != SW - NS) $display("FAIL toggle_dreqs got %0d want %0d", dreqs, SW - NS); else passed++;
        checks++; if (irqs != 1) $display("FAIL toggle_irqs got %0d want 1", irqs); else passed++;
        checks++; if (bad_rd != 0) $display("FAIL toggle_bad_rd got %0d want 0", bad_rd); else passed++;
    endtask

    task automatic test_reset_xfer();
        logic [15:0] word500;
        do_reset();
        push_sync();
        push_body(16'($urandom), 16'($urandom));
        word500 = stim[500];
        run(1'b1, 1'b0, 1'b0, 2, 2, 100, 495, "rst_xfer");
        checks++; if (bus.DREQ_N !== 1'b0 || bus.DATA_DO !== word500) $display("FAIL rst_xfer_word500 dreq_n=%b data=%h want 0/%h", bus.DREQ_N, bus.DATA_DO, word500); else passed++;
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({bus.DREQ_N, bus.SYNCED, bus.SECT_IRQ, bus.SYNC_ERR, bus.WORD_RD, bus.SECT_CNT, bus.DATA_DO, bus.HEADER}
            !== {1'b1, 4'b0, 8'h0, 16'h0, 32'h0})
            $display("FAIL rst_xfer_async got %h want %h",
                     {bus.DREQ_N, bus.SYNCED, bus.SECT_IRQ, bus.SYNC_ERR, bus.WORD_RD, bus.SECT_CNT, bus.DATA_DO, bus.HEADER},
                     {1'b1, 4'b0, 8'h0, 16'h0, 32'h0});
        else passed++;
        do_reset();
        push_sync();
        push_body(16'($urandom), 16'($urandom));
        model();
        run(1'b1, 1'b0, 1'b0, 1, 3, 100, -1, "after_rst");
        checks++; if (first_diff() != -1) $display("FAIL after_rst_order first_diff=%0d got_n=%0d want_n=%0d", first_diff(), got_q.size(), exp_q.size()); else passed++;
        checks++; if (irqs != 1 || bus.SECT_CNT !== 8'd1) $display("FAIL after_rst_sector irqs=%0d cnt=%0d want 1/1", irqs, bus.SECT_CNT); else passed++;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_false_sync();
        test_en_off();
        test_sync_err();
        test_valid_toggle();
        test_reset_xfer();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
